// File: rtl/vga_bank_fader.sv
// vga_bank_fader: VGA scan engine with frame-stepped fade-out / bank switch / fade-in.
// Optional macro: VGA_TEST_PATTERN_EN adds i_test_mode, which swaps RAM pixels for 8 colour bars.
// Ports:
//   clk, rst_n                  pixel clock, async active-low reset
//   i_sel/i_sel_valid/o_sel_ready   picture change request (accepted only in SHOW)
//   o_sel_err                   1-cycle pulse on an accepted out-of-range selection
//   o_pix_bank/o_pix_addr       registered fetch to external sync RAM
//   i_pix_data                  {R,G,B} for the address presented the previous cycle
//   o_frame_start               1-cycle pulse at counter origin
//   VGA_*                       DAC outputs, 2 cycles behind the counters
module vga_bank_fader #(
    parameter int unsigned H_SYNC    = 120,
    parameter int unsigned H_BACK    = 64,
    parameter int unsigned H_DISP    = 800,
    parameter int unsigned H_FRONT   = 56,
    parameter int unsigned V_SYNC    = 6,
    parameter int unsigned V_BACK    = 23,
    parameter int unsigned V_DISP    = 600,
    parameter int unsigned V_FRONT   = 37,
    parameter int unsigned N_PIC     = 4,
    parameter int unsigned FADE_STEP = 32,
    localparam int unsigned SW       = $clog2(N_PIC),
    localparam int unsigned AW       = $clog2(H_DISP * V_DISP)
) (
    input  logic          clk,
    input  logic          rst_n,
`ifdef VGA_TEST_PATTERN_EN
    input  logic          i_test_mode,
`endif
    input  logic [SW-1:0] i_sel,
    input  logic          i_sel_valid,
    output logic          o_sel_ready,
    output logic          o_sel_err,
    output logic [SW-1:0] o_pix_bank,
    output logic [AW-1:0] o_pix_addr,
    input  logic [23:0]   i_pix_data,
    output logic          o_frame_start,
    output logic [7:0]    VGA_R,
    output logic [7:0]    VGA_G,
    output logic [7:0]    VGA_B,
    output logic          VGA_HS,
    output logic          VGA_VS,
    output logic          VGA_BLANK_N,
    output logic          VGA_SYNC_N,
    output logic          VGA_CLK
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned H_ACT   = H_SYNC + H_BACK;
    localparam int unsigned V_ACT   = V_SYNC + V_BACK;
    localparam int unsigned N_PIX   = H_DISP * V_DISP;
    localparam logic [8:0]  LVL_MAX  = 9'd256;
    localparam logic [8:0]  LVL_STEP = 9'(FADE_STEP);
`ifdef VGA_TEST_PATTERN_EN
    localparam int unsigned BAR_W   = H_DISP / 8;
`endif

    typedef enum logic [1:0] {SHOW, FADE_OUT, FADE_IN} state_e;

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          frame_start_c, frame_start_q, frame_start_d;
    logic          disp_s1_q, disp_s1_d, hs_s1_q, hs_s1_d, vs_s1_q, vs_s1_d;
    state_e        state_q, state_d;
    logic [8:0]    level_q, level_d;
    logic [9:0]    lvl_sum_c;
    logic [SW-1:0] bank_q, bank_d, pend_q, pend_d;
    logic          sel_ready_q, sel_ready_d, sel_err_q, sel_err_d;
    logic [23:0]   pix_c;
    logic [7:0]    vga_r_q, vga_r_d, vga_g_q, vga_g_d, vga_b_q, vga_b_d;
    logic          vga_hs_q, vga_hs_d, vga_vs_q, vga_vs_d, vga_bn_q, vga_bn_d;
`ifdef VGA_TEST_PATTERN_EN
    logic [2:0]    bar_s1_q, bar_s1_d;
    logic          tm_s1_q, tm_s1_d;
`endif

    // Per-channel brightness: (c * level) >> 8 with a 17-bit product.
    function automatic logic [7:0] scale(input logic [7:0] c, input logic [8:0] lvl);
        logic [16:0] prod;
        prod = 17'(c) * 17'(lvl);
        return 8'(prod >> 8);
    endfunction

    // S0: scan counters, timing decode and pixel address.
    always_comb begin
        h_cnt_d = h_cnt_q + HW'(1);
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == HW'(H_TOTAL - 1)) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == VW'(V_TOTAL - 1)) ? '0 : v_cnt_q + VW'(1);
        end
        frame_start_c = (h_cnt_q == '0) && (v_cnt_q == '0);
        // Registered pulse lines up with the cycle in which the counters sit at origin.
        frame_start_d = (h_cnt_d == '0) && (v_cnt_d == '0);
        disp_s1_d = (h_cnt_q >= HW'(H_ACT)) && (h_cnt_q < HW'(H_ACT + H_DISP)) &&
                    (v_cnt_q >= VW'(V_ACT)) && (v_cnt_q < VW'(V_ACT + V_DISP));
        hs_s1_d = (h_cnt_q >= HW'(H_SYNC));
        vs_s1_d = (v_cnt_q >= VW'(V_SYNC));
`ifdef VGA_TEST_PATTERN_EN
        bar_s1_d = 3'((32'(h_cnt_q) - H_ACT) / BAR_W);
        tm_s1_d  = i_test_mode;
`endif
        addr_d = addr_q;
        if (frame_start_c) begin
            addr_d = '0;
        end else if (disp_s1_d) begin
            addr_d = (addr_q == AW'(N_PIX - 1)) ? '0 : addr_q + AW'(1);
        end
    end

    // Fade FSM: requests are taken any cycle in SHOW; level/state advance on frame start.
    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        bank_d    = bank_q;
        pend_d    = pend_q;
        sel_err_d = 1'b0;
        lvl_sum_c = 10'(level_q) + 10'(LVL_STEP);
        case (state_q)
            SHOW: begin
                if (i_sel_valid && sel_ready_q) begin
                    if ({1'b0, i_sel} >= (SW + 1)'(N_PIC)) begin
                        sel_err_d = 1'b1;
                    end else if (i_sel != bank_q) begin
                        pend_d  = i_sel;
                        state_d = FADE_OUT;
                    end
                end
            end
            FADE_OUT: begin
                if (frame_start_c) begin
                    level_d = (level_q > LVL_STEP) ? level_q - LVL_STEP : '0;
                    if (level_d == '0) begin
                        bank_d  = pend_q;
                        state_d = FADE_IN;
                    end
                end
            end
            FADE_IN: begin
                if (frame_start_c) begin
                    level_d = (lvl_sum_c >= 10'(LVL_MAX)) ? LVL_MAX : lvl_sum_c[8:0];
                    if (level_d == LVL_MAX) begin
                        state_d = SHOW;
                    end
                end
            end
            default: state_d = SHOW;
        endcase
        sel_ready_d = (state_d == SHOW);
    end

    // S1 -> S2: pixel select, scale and blank.
    always_comb begin
        pix_c = i_pix_data;
`ifdef VGA_TEST_PATTERN_EN
        if (tm_s1_q) begin
            case (bar_s1_q)
                3'd0:    pix_c = 24'hFFFFFF;
                3'd1:    pix_c = 24'hFFFF00;
                3'd2:    pix_c = 24'h00FFFF;
                3'd3:    pix_c = 24'h00FF00;
                3'd4:    pix_c = 24'hFF00FF;
                3'd5:    pix_c = 24'hFF0000;
                3'd6:    pix_c = 24'h0000FF;
                default: pix_c = 24'h000000;
            endcase
        end
`endif
        vga_r_d  = disp_s1_q ? scale(pix_c[23:16], level_q) : '0;
        vga_g_d  = disp_s1_q ? scale(pix_c[15:8],  level_q) : '0;
        vga_b_d  = disp_s1_q ? scale(pix_c[7:0],   level_q) : '0;
        vga_hs_d = hs_s1_q;
        vga_vs_d = vs_s1_q;
        vga_bn_d = disp_s1_q;
    end

    // State and pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            addr_q        <= '0;
            frame_start_q <= 1'b0;
            disp_s1_q     <= 1'b0;
            hs_s1_q       <= 1'b0;
            vs_s1_q       <= 1'b0;
            state_q       <= SHOW;
            level_q       <= LVL_MAX;
            bank_q        <= '0;
            pend_q        <= '0;
            sel_ready_q   <= 1'b1;
            sel_err_q     <= 1'b0;
            vga_r_q       <= '0;
            vga_g_q       <= '0;
            vga_b_q       <= '0;
            vga_hs_q      <= 1'b0;
            vga_vs_q      <= 1'b0;
            vga_bn_q      <= 1'b0;
`ifdef VGA_TEST_PATTERN_EN
            bar_s1_q      <= '0;
            tm_s1_q       <= 1'b0;
`endif
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            addr_q        <= addr_d;
            frame_start_q <= frame_start_d;
            disp_s1_q     <= disp_s1_d;
            hs_s1_q       <= hs_s1_d;
            vs_s1_q       <= vs_s1_d;
            state_q       <= state_d;
            level_q       <= level_d;
            bank_q        <= bank_d;
            pend_q        <= pend_d;
            sel_ready_q   <= sel_ready_d;
            sel_err_q     <= sel_err_d;
            vga_r_q       <= vga_r_d;
            vga_g_q       <= vga_g_d;
            vga_b_q       <= vga_b_d;
            vga_hs_q      <= vga_hs_d;
            vga_vs_q      <= vga_vs_d;
            vga_bn_q      <= vga_bn_d;
`ifdef VGA_TEST_PATTERN_EN
            bar_s1_q      <= bar_s1_d;
            tm_s1_q       <= tm_s1_d;
`endif
        end
    end

    assign o_sel_ready   = sel_ready_q;
    assign o_sel_err     = sel_err_q;
    assign o_pix_bank    = bank_q;
    assign o_pix_addr    = addr_q;
    assign o_frame_start = frame_start_q;
    assign VGA_R         = vga_r_q;
    assign VGA_G         = vga_g_q;
    assign VGA_B         = vga_b_q;
    assign VGA_HS        = vga_hs_q;
    assign VGA_VS        = vga_vs_q;
    assign VGA_BLANK_N   = vga_bn_q;
    assign VGA_SYNC_N    = 1'b0;
    assign VGA_CLK       = clk;

endmodule

// File: tb/tb_vga_bank_fader.sv
// Bench for vga_bank_fader on a 14x7 raster (H 2/2/8/2, V 1/1/4/1), FADE_STEP 128.
// N_PIC is 5 so that a 3-bit select can carry out-of-range values (5, 7).
module tb_vga_bank_fader;

    localparam int unsigned SW = 3;
    localparam int unsigned AW = 5;

    logic          clk;
    logic          rst_n;
    logic [SW-1:0] i_sel;
    logic          i_sel_valid;
    logic          o_sel_ready, o_sel_err;
    logic [SW-1:0] o_pix_bank;
    logic [AW-1:0] o_pix_addr;
    logic [23:0]   i_pix_data;
    logic          o_frame_start;
    logic [7:0]    VGA_R, VGA_G, VGA_B;
    logic          VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK;
`ifdef VGA_TEST_PATTERN_EN
    logic          i_test_mode;
    logic [23:0]   bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
`endif

    vga_bank_fader #(
        .H_SYNC(2), .H_BACK(2), .H_DISP(8), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(1), .V_DISP(4), .V_FRONT(1),
        .N_PIC(5), .FADE_STEP(128)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef VGA_TEST_PATTERN_EN
        .i_test_mode(i_test_mode),
`endif
        .i_sel(i_sel),
        .i_sel_valid(i_sel_valid),
        .o_sel_ready(o_sel_ready),
        .o_sel_err(o_sel_err),
        .o_pix_bank(o_pix_bank),
        .o_pix_addr(o_pix_addr),
        .i_pix_data(i_pix_data),
        .o_frame_start(o_frame_start),
        .VGA_R(VGA_R),
        .VGA_G(VGA_G),
        .VGA_B(VGA_B),
        .VGA_HS(VGA_HS),
        .VGA_VS(VGA_VS),
        .VGA_BLANK_N(VGA_BLANK_N),
        .VGA_SYNC_N(VGA_SYNC_N),
        .VGA_CLK(VGA_CLK)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Picture RAM model: mode 0 -> data = addr; mode 1 -> R=FF, G=bank<<3, B=addr.
    logic ram_mode;
    function automatic logic [23:0] ram_f(input logic [4:0] a, input logic [2:0] b, input logic m);
        return m ? {8'hFF, 2'b0, b, 3'b0, 3'b0, a} : {19'b0, a};
    endfunction
    always @(posedge clk) i_pix_data <= ram_f(o_pix_addr, o_pix_bank, ram_mode);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] sc(input logic [7:0] c, input int lvl);
        int p;
        p = int'(c) * lvl;
        return 8'(p / 256);
    endfunction

    // Reference model state (values for the current cycle).
    int  mh, mv, maddr, mlevel, mstate, mbank, mpend;
    bit  merr, mfirst;
    logic [26:0] sbq[$];

    // Scoreboard: compare this cycle, push the VGA word due 2 cycles later, advance model.
    task automatic sb_cycle();
        logic [26:0] got_v, exp_v;
        logic [23:0] pix;
        bit fs, disp;
        got_v = {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N};
        if (!rst_n) begin
            check("rst_vga", 32'(got_v), 32'd0);
            check("rst_ctl", 32'({o_frame_start, o_sel_err, o_pix_bank, o_pix_addr}), 32'd0);
            mh = 0; mv = 0; maddr = 0; mlevel = 256; mstate = 0; mbank = 0; mpend = 0;
            merr = 1'b0; mfirst = 1'b1;
            sbq.delete();
            sbq.push_back('0);
            sbq.push_back('0);
            return;
        end
        fs   = (mh == 0) && (mv == 0);
        disp = (mh >= 4) && (mh < 12) && (mv >= 2) && (mv < 6);
        check("frame_start", 32'(o_frame_start), 32'(fs && !mfirst));
        check("pix_addr", 32'(o_pix_addr), 32'(maddr));
        check("pix_bank", 32'(o_pix_bank), 32'(mbank));
        check("sel_ready", 32'(o_sel_ready), 32'(mstate == 0));
        check("sel_err", 32'(o_sel_err), 32'(merr));
        pix = ram_f(5'(maddr), 3'(mbank), ram_mode);
`ifdef VGA_TEST_PATTERN_EN
        if (i_test_mode && disp) pix = bars[mh - 4];
`endif
        exp_v = disp ? {sc(pix[23:16], mlevel), sc(pix[15:8], mlevel), sc(pix[7:0], mlevel), 3'b0} : 27'd0;
        exp_v[2] = (mh >= 2);
        exp_v[1] = (mv >= 1);
        exp_v[0] = disp;
        sbq.push_back(exp_v);
        check("vga", 32'(got_v), 32'(sbq.pop_front()));
        merr = 1'b0;
        case (mstate)
            0: if (i_sel_valid) begin
                if (int'(i_sel) >= 5) merr = 1'b1;
                else if (int'(i_sel) != mbank) begin mpend = int'(i_sel); mstate = 1; end
            end
            1: if (fs) begin
                mlevel = (mlevel > 128) ? mlevel - 128 : 0;
                if (mlevel == 0) begin mbank = mpend; mstate = 2; end
            end
            default: if (fs) begin
                mlevel = (mlevel + 128 > 256) ? 256 : mlevel + 128;
                if (mlevel == 256) mstate = 0;
            end
        endcase
        if (fs) maddr = 0;
        else if (disp) maddr = (maddr == 31) ? 0 : maddr + 1;
        if (mh == 13) begin
            mh = 0;
            mv = (mv == 6) ? 0 : mv + 1;
        end else begin
            mh = mh + 1;
        end
        mfirst = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        sb_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fs();
        int n = 0;
        do begin tick(); n++; end while (!o_frame_start && n < 200);
        check("fs_wait", 32'(o_frame_start), 32'd1);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!o_sel_ready && n < 800) begin tick(); n++; end
        check("ready_wait", 32'(o_sel_ready), 32'd1);
    endtask

    task automatic send_req(input logic [2:0] sel);
        wait_ready();
        i_sel = sel;
        i_sel_valid = 1'b1;
        tick();
        i_sel_valid = 1'b0;
    endtask

    typedef struct {
        logic [2:0] sel;
        logic       exp_err;
        logic       exp_fade;
        logic [2:0] exp_bank;
    } req_t;

    req_t       tbl [6];
    logic [7:0] lvl_r [4] = '{8'h7F, 8'h00, 8'h7F, 8'hFF};

    initial begin
        int n, hs_lo, bn_hi;
        tbl[0] = '{3'd0, 1'b0, 1'b0, 3'd0};
        tbl[1] = '{3'd5, 1'b1, 1'b0, 3'd0};
        tbl[2] = '{3'd7, 1'b1, 1'b0, 3'd0};
        tbl[3] = '{3'd2, 1'b0, 1'b1, 3'd2};
        tbl[4] = '{3'd2, 1'b0, 1'b0, 3'd2};
        tbl[5] = '{3'd1, 1'b0, 1'b1, 3'd1};

        rst_n = 1'b0; i_sel = '0; i_sel_valid = 1'b0; ram_mode = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
        i_test_mode = 1'b0;
`endif
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("sync_n", 32'(VGA_SYNC_N), 32'd0);
        check("vga_clk", 32'(VGA_CLK), 32'(clk));

        // Raster: frame period, HS low and BLANK_N high counts over one frame.
        wait_fs();
        n = 0; hs_lo = 0; bn_hi = 0;
        do begin
            tick(); n++;
            if (!VGA_HS) hs_lo++;
            if (VGA_BLANK_N) bn_hi++;
        end while (!o_frame_start && n < 200);
        check("frame_period", 32'(n), 32'd98);
        check("hs_low_cnt", 32'(hs_lo), 32'd14);
        check("blank_n_cnt", 32'(bn_hi), 32'd32);

        // First visible pixel is address 0, the next address 1.
        repeat (34) tick();
        check("first_pix", 32'({VGA_R, VGA_G, VGA_B}), 32'd0);
        tick();
        check("second_pix", 32'({VGA_R, VGA_G, VGA_B}), 32'd1);

        // Request table, data R=FF so per-frame level is visible on VGA_R.
        ram_mode = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send_req(tbl[i].sel);
            check("req_err", 32'(o_sel_err), 32'(tbl[i].exp_err));
            check("req_ready", 32'(o_sel_ready), 32'(!tbl[i].exp_fade));
            if (tbl[i].exp_fade) begin
                for (int k = 0; k < 4; k++) begin
                    wait_fs();
                    repeat (34) tick();
                    check("fade_r", 32'(VGA_R), 32'(lvl_r[k]));
                    check("fade_ready", 32'(o_sel_ready), 32'(k == 3));
                end
            end else begin
                tick();
                check("err_clear", 32'(o_sel_err), 32'd0);
            end
            tick();
            check("req_bank", 32'(o_pix_bank), 32'(tbl[i].exp_bank));
            check("req_ready_end", 32'(o_sel_ready), 32'd1);
        end

        // Request on the frame-start cycle: fade starts only at the following frame start.
        wait_ready();
        wait_fs();
        i_sel = 3'd3;
        i_sel_valid = 1'b1;
        tick();
        i_sel_valid = 1'b0;
        check("fs_req_ready", 32'(o_sel_ready), 32'd0);
        repeat (33) tick();
        check("fs_req_r0", 32'(VGA_R), 32'hFF);
        wait_fs();
        repeat (34) tick();
        check("fs_req_r1", 32'(VGA_R), 32'h7F);
        wait_ready();
        check("fs_req_bank", 32'(o_pix_bank), 32'd3);

        // Reset in the middle of a fade-out discards the pending request.
        send_req(3'd4);
        wait_fs();
        repeat (34) tick();
        check("mid_fade_r", 32'(VGA_R), 32'h7F);
        rst_n = 1'b0;
        repeat (3) tick();
        check("in_rst_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", 32'(o_sel_ready), 32'd1);
        check("post_rst_bank", 32'(o_pix_bank), 32'd0);
        wait_fs();
        repeat (34) tick();
        check("post_rst_r", 32'(VGA_R), 32'hFF);
        wait_fs();
        wait_fs();
        check("post_rst_bank2", 32'(o_pix_bank), 32'd0);
        check("post_rst_ready2", 32'(o_sel_ready), 32'd1);

`ifdef VGA_TEST_PATTERN_EN
        // Colour bars across the first visible line at full level.
        i_test_mode = 1'b1;
        wait_fs();
        repeat (34) tick();
        for (int k = 0; k < 8; k++) begin
            check("bar", 32'({VGA_R, VGA_G, VGA_B}), 32'(bars[k]));
            tick();
        end
        i_test_mode = 1'b0;
        repeat (100) tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
